// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
//   Shared definitions for the seq_detect serial pattern detector. The package
//   provides the maximum pattern length, the table types, and the constant
//   functions that build the KMP failure table, the per-state transition table
//   and the state register width at elaboration time.
// -----------------------------------------------------------------------------
package seq_detect_pkg;

   localparam int unsigned MAX_PAT_LEN = 16;
   localparam int unsigned LEN_W       = $clog2(MAX_PAT_LEN + 1);
   localparam int unsigned IDX_W       = $clog2(MAX_PAT_LEN);

   typedef logic [LEN_W-1:0]                len_t;
   typedef logic [MAX_PAT_LEN-1:0]          pat_t;
   typedef len_t [MAX_PAT_LEN:0]            fail_tab_t;
   typedef len_t [MAX_PAT_LEN-1:0][1:0]     delta_tab_t;

   // Width of a register that holds a prefix length 0..len.
   function automatic int unsigned state_width(input int unsigned len);
      return $clog2(len + 1);
   endfunction

   // Pattern bit i in arrival order: bit 0 is the MSB of the pattern value.
   function automatic logic pat_bit(input pat_t pat, input int unsigned len,
                                    input int unsigned i);
      pat_t sh;
      sh = pat >> (len - 1 - i);
      return sh[0];
   endfunction

   // f[k] = length of the longest proper prefix of the first k pattern bits
   // that is also a suffix of them.
   function automatic fail_tab_t fail_table(input int unsigned len, input pat_t pat);
      fail_tab_t f;
      len_t      k;
      f = '0;
      k = '0;
      for (int unsigned i = 1; i < MAX_PAT_LEN; i++) begin
         if (i < len) begin
            // Bounded unroll of the classic KMP while-loop: once a prefix
            // extends or k reaches zero, further iterations do nothing.
            for (int unsigned j = 0; j < MAX_PAT_LEN; j++) begin
               if (k != '0 && pat_bit(pat, len, i) != pat_bit(pat, len, 32'(k)))
                  k = f[k];
            end
            if (pat_bit(pat, len, i) == pat_bit(pat, len, 32'(k)))
               k = k + 1'b1;
            f[LEN_W'(i + 1)] = k;
         end
      end
      return f;
   endfunction

   // d[s][b] = next prefix length from state s (< len) on input bit b,
   // following the failure chain until a prefix extends. A value of len
   // means a full match.
   function automatic delta_tab_t delta_table(input int unsigned len, input pat_t pat);
      fail_tab_t  f;
      delta_tab_t d;
      len_t       k;
      logic       done;
      f = fail_table(len, pat);
      d = '0;
      for (int unsigned s = 0; s < MAX_PAT_LEN; s++) begin
         for (int unsigned b = 0; b < 2; b++) begin
            if (s < len) begin
               k    = LEN_W'(s);
               done = 1'b0;
               for (int unsigned j = 0; j <= MAX_PAT_LEN; j++) begin
                  if (!done) begin
                     if (pat_bit(pat, len, 32'(k)) == b[0]) begin
                        d[IDX_W'(s)][b[0]] = k + 1'b1;
                        done = 1'b1;
                     end else if (k == '0) begin
                        d[IDX_W'(s)][b[0]] = '0;
                        done = 1'b1;
                     end else begin
                        k = f[k];
                     end
                  end
               end
            end
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/seq_detect_cnt.sv
// -----------------------------------------------------------------------------
// seq_detect_cnt
//   Saturating match counter with synchronous clear and a sticky saturation
//   flag.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   inc   : count one match on this edge
//   clear : synchronous clear; a coincident inc leaves the count at 1
//   cnt   : saturating count (CNT_W bits)
//   sat   : set when cnt reaches all-ones, cleared only by clear or rst
// -----------------------------------------------------------------------------
module seq_detect_cnt #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   logic [CNT_W-1:0] cnt_inc;

   always_comb begin
      cnt_inc = cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (clear) begin
         cnt <= inc ? CNT_W'(1) : '0;
         sat <= 1'b0;
      end else if (inc && cnt != '1) begin
         cnt <= cnt_inc;
         sat <= &cnt_inc;
      end
   end

endmodule

// File: rtl/seq_detect.sv
// -----------------------------------------------------------------------------
// seq_detect
//   Parametrised serial pattern detector. The state is the length of the
//   longest PATTERN prefix that is a suffix of the consumed bits; transitions
//   come from a KMP-derived table built at elaboration.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : qualifies stream; bits are consumed only when high
//   stream    : serial data bit (PATTERN MSB arrives first)
//   clear_cnt : synchronous clear of match_cnt and cnt_sat
//   match     : pattern detected (Mealy: same cycle, Moore: next cycle)
//   match_cnt : saturating count of detected matches
//   cnt_sat   : sticky, counter has reached all-ones
// -----------------------------------------------------------------------------
module seq_detect
   import seq_detect_pkg::*;
#(
   parameter int unsigned        PAT_LEN   = 4,
   parameter logic [PAT_LEN-1:0] PATTERN   = 4'b1011,
   parameter logic               MEALY_FSM = 1'b0,
   parameter logic               OVERLAP   = 1'b1,
   parameter int unsigned        CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             stream,
   input  logic             clear_cnt,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   generate
      if (PAT_LEN < 2 || PAT_LEN > MAX_PAT_LEN) begin : g_len_check
         $error("seq_detect: PAT_LEN must be in 2..16");
      end
   endgenerate

   localparam int unsigned SW = state_width(PAT_LEN);
   typedef logic [SW-1:0] state_t;

   localparam pat_t       PAT_EXT = pat_t'(PATTERN);
   localparam fail_tab_t  FAIL    = fail_table(PAT_LEN, PAT_EXT);
   localparam delta_tab_t DELTA   = delta_table(PAT_LEN, PAT_EXT);
   localparam state_t     FULL    = SW'(PAT_LEN);
   localparam state_t     CONT    = OVERLAP ? SW'(FAIL[LEN_W'(PAT_LEN)]) : '0;

   state_t           state;
   state_t           base;
   logic [IDX_W-1:0] idx;
   len_t             nxt;
   logic             hit;
   logic             moore_q;

   // In Moore mode the full-match state is only a display state: the next
   // bit is evaluated from the continuation state instead.
   always_comb begin
      base = state;
      if (!MEALY_FSM && state == FULL)
         base = CONT;
      idx = IDX_W'(base);
      nxt = DELTA[idx][stream];
      hit = in_valid && (nxt == LEN_W'(PAT_LEN));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= '0;
         moore_q <= 1'b0;
      end else if (in_valid) begin
         if (hit)
            state <= MEALY_FSM ? CONT : FULL;
         else
            state <= SW'(nxt);
         moore_q <= hit;
      end
   end

   assign match = MEALY_FSM ? (hit && !rst) : moore_q;

   seq_detect_cnt #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit),
      .clear (clear_cnt),
      .cnt   (match_cnt),
      .sat   (cnt_sat)
   );

endmodule

// File: tb/tb_seq_detect.sv
// -----------------------------------------------------------------------------
// tb_seq_detect
//   Directed bench for seq_detect. Four instances share clock and stimulus:
//   u_a Mealy/overlap 1011, u_b Moore/non-overlap 1011, u_c Moore/non-overlap
//   1011 with a 2-bit counter, u_d Mealy/overlap 11011.
// -----------------------------------------------------------------------------
module tb_seq_detect;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       stream;
   logic       clear_cnt;

   logic       a_match, b_match, c_match, d_match;
   logic [7:0] a_cnt, b_cnt, d_cnt;
   logic [1:0] c_cnt;
   logic       a_sat, b_sat, c_sat, d_sat;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_detect #(.PAT_LEN(4), .PATTERN(4'b1011), .MEALY_FSM(1'b1), .OVERLAP(1'b1), .CNT_W(8)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stream(stream), .clear_cnt(clear_cnt),
      .match(a_match), .match_cnt(a_cnt), .cnt_sat(a_sat));

   seq_detect #(.PAT_LEN(4), .PATTERN(4'b1011), .MEALY_FSM(1'b0), .OVERLAP(1'b0), .CNT_W(8)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stream(stream), .clear_cnt(clear_cnt),
      .match(b_match), .match_cnt(b_cnt), .cnt_sat(b_sat));

   seq_detect #(.PAT_LEN(4), .PATTERN(4'b1011), .MEALY_FSM(1'b0), .OVERLAP(1'b0), .CNT_W(2)) u_c (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stream(stream), .clear_cnt(clear_cnt),
      .match(c_match), .match_cnt(c_cnt), .cnt_sat(c_sat));

   seq_detect #(.PAT_LEN(5), .PATTERN(5'b11011), .MEALY_FSM(1'b1), .OVERLAP(1'b1), .CNT_W(8)) u_d (
      .clk(clk), .rst(rst), .in_valid(in_valid), .stream(stream), .clear_cnt(clear_cnt),
      .match(d_match), .match_cnt(d_cnt), .cnt_sat(d_sat));

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one bit at the falling edge; the caller samples Mealy outputs
   // right after, before the consuming rising edge.
   task automatic put(input logic v, input logic b, input logic c);
      @(negedge clk);
      in_valid  = v;
      stream    = b;
      clear_cnt = c;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      stream    = 1'b0;
      clear_cnt = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] p1_bits, p1_mealy, p1_moore;
      logic [7:0] p5_bits, p5_mealy;
      logic [7:0] exp_cnt;

      rst       = 1'b1;
      in_valid  = 1'b0;
      stream    = 1'b0;
      clear_cnt = 1'b0;
      #3;
      chk1("rst_a_match", a_match, 1'b0);
      chk8("rst_a_cnt",   a_cnt,   8'd0);
      chk1("rst_a_sat",   a_sat,   1'b0);
      chk1("rst_b_match", b_match, 1'b0);
      chk8("rst_c_cnt",   8'(c_cnt), 8'd0);
      chk1("rst_d_match", d_match, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Stream 1,0,1,1,0,1,1: Mealy overlap hits bits 4 and 7,
      // Moore non-overlap flags only the cycle after bit 4.
      p1_bits  = 7'b1011011;
      p1_mealy = 7'b0001001;
      p1_moore = 7'b0001000;
      for (int i = 6; i >= 0; i--) begin
         put(1'b1, p1_bits[i], 1'b0);
         chk1("p1_mealy_match", a_match, p1_mealy[i]);
         tick();
         chk1("p1_moore_match", b_match, p1_moore[i]);
      end
      chk8("p1_a_cnt", a_cnt, 8'd2);
      chk8("p1_b_cnt", b_cnt, 8'd1);

      // in_valid gap with a toggling stream between 1,0 and 1,1.
      do_reset();
      put(1'b1, 1'b1, 1'b0); tick();
      put(1'b1, 1'b0, 1'b0); tick();
      for (int k = 0; k < 5; k++) begin
         put(1'b0, (k % 2 == 0), 1'b0);
         chk1("gap_a_match", a_match, 1'b0);
         tick();
         chk1("gap_b_match", b_match, 1'b0);
      end
      put(1'b1, 1'b1, 1'b0);
      chk1("gap_a_bit3", a_match, 1'b0);
      tick();
      put(1'b1, 1'b1, 1'b0);
      chk1("gap_a_bit4", a_match, 1'b1);
      tick();
      chk1("gap_b_match_after", b_match, 1'b1);
      chk8("gap_a_cnt", a_cnt, 8'd1);
      chk8("gap_b_cnt", b_cnt, 8'd1);
      put(1'b0, 1'b0, 1'b0);
      chk1("idle_a_match", a_match, 1'b0);
      tick();
      chk1("idle_b_hold", b_match, 1'b1);

      // Reset mid-pattern: u_a sits at prefix 101, and the bit presented
      // while rst is high would otherwise complete 1011.
      put(1'b1, 1'b1, 1'b0); tick();
      put(1'b1, 1'b0, 1'b0); tick();
      put(1'b1, 1'b1, 1'b0); tick();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      stream   = 1'b1;
      #1;
      chk1("midrst_a_match", a_match, 1'b0);
      chk8("midrst_a_cnt", a_cnt, 8'd0);
      tick();
      chk1("midrst_a_match_edge", a_match, 1'b0);
      chk8("midrst_a_cnt_edge", a_cnt, 8'd0);
      in_valid = 1'b0;
      rst      = 1'b0;
      put(1'b1, 1'b1, 1'b0);
      chk1("postrst_first_bit", a_match, 1'b0);
      tick();
      put(1'b1, 1'b0, 1'b0); tick();
      put(1'b1, 1'b1, 1'b0); tick();
      put(1'b1, 1'b1, 1'b0);
      chk1("postrst_match", a_match, 1'b1);
      tick();
      chk8("postrst_a_cnt", a_cnt, 8'd1);

      // Saturation of a 2-bit counter over five non-overlapping matches.
      do_reset();
      for (int r = 0; r < 5; r++) begin
         put(1'b1, 1'b1, 1'b0); tick();
         put(1'b1, 1'b0, 1'b0); tick();
         put(1'b1, 1'b1, 1'b0); tick();
         put(1'b1, 1'b1, 1'b0); tick();
         exp_cnt = (r + 1 > 3) ? 8'd3 : 8'(r + 1);
         chk8("sat_c_cnt", 8'(c_cnt), exp_cnt);
         chk1("sat_c_flag", c_sat, (r >= 2));
      end
      chk8("sat_b_cnt", b_cnt, 8'd5);
      put(1'b1, 1'b1, 1'b0); tick();
      put(1'b1, 1'b0, 1'b0); tick();
      put(1'b1, 1'b1, 1'b0); tick();
      put(1'b1, 1'b1, 1'b1); tick();
      chk8("clrhit_c_cnt", 8'(c_cnt), 8'd1);
      chk1("clrhit_c_sat", c_sat, 1'b0);
      chk8("clrhit_b_cnt", b_cnt, 8'd1);
      put(1'b0, 1'b0, 1'b1); tick();
      chk8("clr_c_cnt", 8'(c_cnt), 8'd0);
      chk8("clr_b_cnt", b_cnt, 8'd0);
      clear_cnt = 1'b0;

      // 11011 overlapping: second hit relies on fail(5)=2.
      do_reset();
      p5_bits  = 8'b11011011;
      p5_mealy = 8'b00001001;
      for (int i = 7; i >= 0; i--) begin
         put(1'b1, p5_bits[i], 1'b0);
         chk1("p5_d_match", d_match, p5_mealy[i]);
         tick();
      end
      chk8("p5_d_cnt", d_cnt, 8'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_detect.md
Name: seq_detect

Overview:
- Parametrised serial pattern detector: the successor to the fixed "1011" fsm_ctrl detector.
- Adds programmable pattern length and value, Mealy/Moore selection, overlapping or non-overlapping matching, input qualification and a saturating match counter.
- Sits after any 1-bit serial source and flags every occurrence of PATTERN in the qualified bit stream.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1011, pattern value [PAT_LEN-1:0]; the MSB is the first bit received.
- MEALY_FSM, 1'b0, 1 = Mealy (combinational match), 0 = Moore (registered match).
- OVERLAP, 1'b1, 1 = overlapping matches allowed, 0 = restart from empty after each match.
- CNT_W, 8, match counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies stream; bits are consumed only when in_valid=1.
- stream  in  1  serial data bit.
- clear_cnt  in  1  synchronous clear of match_cnt and cnt_sat.
- match  out  1  pattern-detected flag.
- match_cnt  out  CNT_W  saturating count of detected matches.
- cnt_sat  out  1  sticky flag: counter has reached all-ones.

Behaviour:
- Reset: rst is asynchronous and active-high. It forces state=0, match_cnt=0, cnt_sat=0 and match=0; in Mealy mode match is 0 while rst is high.
- State meaning: the state is the length of the longest PATTERN prefix that is a suffix of the consumed bits.
  - Mealy states: 0..PAT_LEN-1. Moore states: 0..PAT_LEN.
- Transition on a consumed bit b from state s (s<PAT_LEN):
  - If PATTERN[PAT_LEN-1-s]==b, go to s+1.
  - Otherwise follow the failure function (KMP prefix table) until a prefix extends, or go to 0.
  - The failure table is computed at elaboration by a constant function. No runtime pattern storage.
- Full match (reaching length PAT_LEN):
  - OVERLAP=1: continue from fail(PAT_LEN).
  - OVERLAP=0: continue from 0.
  - Mealy: the state register loads that continuation directly.
  - Moore: the state register enters PAT_LEN. The next consumed bit is evaluated from fail(PAT_LEN) (OVERLAP=1) or from 0 (OVERLAP=0).
- Mealy match = in_valid & (transition reaches PAT_LEN). Combinational, zero latency, same cycle as the last pattern bit.
- Moore match = (state==PAT_LEN). Asserts in the cycle after the edge that consumed the last bit, i.e. one cycle of latency.
- in_valid=0:
  - The state holds.
  - Mealy match=0.
  - Moore match holds its value, since it is state-derived.
- Counter:
  - Increments by 1 on the clock edge at which a match is detected. In both modes this is the edge consuming the last pattern bit.
  - Saturates at 2^CNT_W-1; cnt_sat sets and stays set.
- clear_cnt=1 with no match on the same edge: match_cnt becomes 0 and cnt_sat becomes 0.
- clear_cnt=1 coincident with a match: match_cnt becomes 1 and cnt_sat becomes 0.
- rst mid-pattern: the partial match is discarded. Detection restarts from state 0 on the first consumed bit after rst deasserts.
- Width rule: the state register is $clog2(PAT_LEN+1) bits wide. Out-of-range PAT_LEN is an elaboration error, raised by a generate-time $error.

Decomposition:
- Shared package seq_detect_pkg holds:
  - the MAX_PAT_LEN=16 constant;
  - the constant function for the failure table;
  - the constant function for the state width.
- Sub-module seq_detect_cnt holds the saturating counter with clear and sticky saturation.
- The FSM stays in the top module.

Test Plan:
- Overlap Mealy, default pattern 1011, stream 1,0,1,1,0,1,1 with in_valid=1 -> match=1 at bits 4 and 7 (same cycle); match_cnt=2.
- Non-overlap Moore, same stream -> match=1 in the cycle after bit 4 only; match_cnt=1; state returns to 0.
- in_valid gaps: bits 1,0 then in_valid=0 for 5 cycles with stream toggling, then 1,1 -> exactly one match; no spurious detection during the gap.
- Reset mid-pattern: bits 1,0,1, then rst pulse, then 1 -> no match. Following 0,1,1 -> match; match_cnt=1 after reset.
- Saturation with CNT_W=2: stream 1011 repeated 5 times (non-overlap) -> match_cnt stops at 3 with cnt_sat=1. Then clear_cnt coincident with a 6th match -> match_cnt=1, cnt_sat=0.
- PAT_LEN=5, PATTERN=5'b11011, overlap, stream 1,1,0,1,1,0,1,1 -> matches at bits 5 and 8 (fail(5)=2 exercised); match_cnt=2.
